// File: rtl/mips_multicycle_r.sv
// Multicycle MIPS R-type core: FETCH/DECODE/EXEC/WB over a preloadable
// instruction memory and a 32-entry register file.
module mips_multicycle_r #(
   parameter int DATA_W  = 32,
   parameter int IMEM_AW = 4,
   parameter int MON_REG = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                imem_we,
   input  logic [IMEM_AW-1:0]  imem_waddr,
   input  logic [31:0]         imem_wdata,
   input  logic                reg_we,
   input  logic [4:0]          reg_waddr,
   input  logic [DATA_W-1:0]   reg_wdata,
   output logic                busy,
   output logic                done,
   output logic                illegal,
   output logic [15:0]         instr_count,
   output logic [DATA_W-1:0]   mon_data,
   output logic                alu_zero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_DONE
   } state_t;

   localparam logic [4:0]  MON_IDX = 5'(MON_REG);
   localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

   state_t              state_q, state_d;
   logic [IMEM_AW-1:0]  pc_q, pc_d;
   logic [31:0]         ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   aluout_q, aluout_d;
   logic [DATA_W-1:0]   regs_q [32];
   logic [DATA_W-1:0]   regs_d [32];
   logic [15:0]         cnt_q, cnt_d;
   logic                ill_q, ill_d;
   logic                bad_q, bad_d;
   logic                zero_q, zero_d;
   logic [31:0]         imem_q [2**IMEM_AW];

   logic [5:0]          op;
   logic [4:0]          rs;
   logic [4:0]          rt;
   logic [4:0]          rd;
   logic [5:0]          funct;
   logic                unused_shamt;

   logic [DATA_W-1:0]   res;
   logic                legal;

   assign op           = ir_q[31:26];
   assign rs           = ir_q[25:21];
   assign rt           = ir_q[20:16];
   assign rd           = ir_q[15:11];
   assign funct        = ir_q[5:0];
   assign unused_shamt = ^ir_q[10:6];

   always_comb begin
      res   = '0;
      legal = (op == 6'd0);
      unique case (funct)
         6'h20: res = a_q + b_q;
         6'h22: res = a_q - b_q;
         6'h24: res = a_q & b_q;
         6'h25: res = a_q | b_q;
         6'h27: res = ~(a_q | b_q);
         6'h2A: res = {{(DATA_W-1){1'b0}},
                       ($signed(a_q) < $signed(b_q))};
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      aluout_d = aluout_q;
      cnt_d    = cnt_q;
      ill_d    = ill_q;
      bad_d    = bad_q;
      zero_d   = zero_q;
      regs_d   = regs_q;
      unique case (state_q)
         S_IDLE: begin
            if (reg_we && reg_waddr != 5'd0)
               regs_d[reg_waddr] = reg_wdata;
            if (start) begin
               pc_d    = '0;
               cnt_d   = '0;
               ill_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            ir_d    = imem_q[pc_q];
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d     = regs_q[rs];
            b_d     = regs_q[rt];
            state_d = (ir_q == HALT) ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            // illegal ops still retire; bad_q only blocks the WB write
            if (legal) begin
               aluout_d = res;
               zero_d   = (res == '0);
               bad_d    = 1'b0;
            end else begin
               bad_d = 1'b1;
               ill_d = 1'b1;
            end
            state_d = S_WB;
         end
         S_WB: begin
            if (!bad_q && rd != 5'd0)
               regs_d[rd] = aluout_q;
            if (cnt_q != 16'hFFFF)
               cnt_d = cnt_q + 16'd1;
            if (&pc_q) begin
               state_d = S_DONE;
            end else begin
               pc_d    = pc_q + IMEM_AW'(1);
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         cnt_q    <= '0;
         ill_q    <= 1'b0;
         bad_q    <= 1'b0;
         zero_q   <= 1'b0;
         for (int i = 0; i < 32; i++)
            regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         cnt_q    <= cnt_d;
         ill_q    <= ill_d;
         bad_q    <= bad_d;
         zero_q   <= zero_d;
         for (int i = 0; i < 32; i++)
            regs_q[i] <= regs_d[i];
      end
   end

   // program storage survives reset
   always_ff @(posedge clk) begin
      if (imem_we && state_q == S_IDLE)
         imem_q[imem_waddr] <= imem_wdata;
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign illegal     = ill_q;
   assign instr_count = cnt_q;
   assign mon_data    = regs_q[MON_IDX];
   assign alu_zero    = zero_q;

endmodule

// File: tb/tb_mips_multicycle_r.sv
// Bench for mips_multicycle_r: directed scenarios plus random programs
// compared against an instruction-level model.
module tb_mips_multicycle_r;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        imem_we;
   logic [3:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [15:0] instr_count;
   logic [31:0] mon_data;
   logic        alu_zero;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_reg [32];
   logic [31:0] m_imem [16];
   logic        m_zero;

   mips_multicycle_r #(
      .DATA_W(32), .IMEM_AW(4), .MON_REG(20)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .reg_we(reg_we),
      .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .busy(busy), .done(done), .illegal(illegal),
      .instr_count(instr_count), .mon_data(mon_data),
      .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(int s, int t, int d,
                                         logic [5:0] f);
      return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, f};
   endfunction

   task automatic wr_imem(int a, logic [31:0] w);
      imem_we = 1'b1; imem_waddr = 4'(a); imem_wdata = w;
      @(posedge clk); #1 imem_we = 1'b0;
      m_imem[a] = w;
   endtask

   task automatic wr_reg(int r, logic [31:0] v);
      reg_we = 1'b1; reg_waddr = 5'(r); reg_wdata = v;
      @(posedge clk); #1 reg_we = 1'b0;
      if (r != 0) m_reg[r] = v;
   endtask

   task automatic wait_done(output int cyc, output bit seen);
      cyc = 0; seen = 0;
      while (!seen && cyc < 200) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic run_dut(output int cyc, output bit seen);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(cyc, seen);
   endtask

   // instruction-level reference: one loop step per instruction
   task automatic model_run(output int cnt, output bit ill,
                            output int cyc);
      logic [31:0] w, a, b, r;
      bit ok, halted;
      cnt = 0; ill = 0; halted = 0;
      for (int pc = 0; pc < 16 && !halted; pc++) begin
         w = m_imem[pc];
         if (w == HALT) begin
            halted = 1;
         end else begin
            a = m_reg[w[25:21]]; b = m_reg[w[20:16]];
            ok = (w[31:26] == 6'd0); r = 0;
            case (w[5:0])
               6'h20: r = a + b;
               6'h22: r = a - b;
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h27: r = ~(a | b);
               6'h2A: r = ($signed(a) < $signed(b)) ? 1 : 0;
               default: ok = 0;
            endcase
            if (!ok) ill = 1;
            else begin
               m_zero = (r == 0);
               if (w[15:11] != 0) m_reg[w[15:11]] = r;
            end
            cnt++;
         end
      end
      cyc = halted ? 4 * cnt + 2 : 4 * cnt;
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_cmp++;
      if ({busy, done, illegal, alu_zero} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {busy, done, illegal, alu_zero});
      end
      n_cmp++;
      if (instr_count !== 16'd0 || mon_data !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_data: got cnt=%0d mon=%0d expected 0/0",
                  instr_count, mon_data);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_busy: got %b expected 0", busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sub_899;
      wr_reg(15, 999); wr_reg(9, 100);
      wr_imem(0, 32'h01E9A022); wr_imem(1, HALT);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); @(negedge clk);
         if (k == 3) begin
            n_cmp++;
            if (mon_data !== 32'd0) begin
               n_bad++;
               $display("FAIL mon_before_wb: got %0d expected 0", mon_data);
            end
         end
         if (k == 4) begin
            n_cmp++;
            if (mon_data !== 32'd899) begin
               n_bad++;
               $display("FAIL mon_after_wb: got %0d expected 899", mon_data);
            end
         end
         if (k == 5 || k == 6) begin
            n_cmp++;
            if (done !== (k == 6)) begin
               n_bad++;
               $display("FAIL done_timing k=%0d: got %b expected %b",
                        k, done, k == 6);
            end
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || instr_count !== 16'd1) begin
         n_bad++;
         $display("FAIL sub_end: got busy=%b done=%b cnt=%0d expected 0/0/1",
                  busy, done, instr_count);
      end
      m_reg[20] = 899; m_zero = 0;
   endtask

   task automatic test_add_1019;
      int cyc; bit seen;
      wr_reg(5, 20); wr_reg(15, 999);
      wr_imem(0, rtype(5, 15, 15, 6'h20));
      wr_imem(1, rtype(15, 0, 20, 6'h25));
      wr_imem(2, HALT);
      run_dut(cyc, seen);
      n_cmp++;
      if (!seen || cyc != 10) begin
         n_bad++;
         $display("FAIL add_cycles: got seen=%0d cyc=%0d expected 1/10",
                  seen, cyc);
      end
      n_cmp++;
      if (mon_data !== 32'd1019 || alu_zero !== 1'b0) begin
         n_bad++;
         $display("FAIL add_1019: got mon=%0d z=%b expected 1019/0",
                  mon_data, alu_zero);
      end
      m_reg[15] = 1019; m_reg[20] = 1019; m_zero = 0;
   endtask

   task automatic test_zero;
      int cyc; bit seen;
      wr_imem(0, rtype(9, 9, 20, 6'h22)); wr_imem(1, HALT);
      run_dut(cyc, seen);
      n_cmp++;
      if (!seen || mon_data !== 32'd0 || alu_zero !== 1'b1) begin
         n_bad++;
         $display("FAIL sub_zero: got seen=%0d mon=%0d z=%b expected 1/0/1",
                  seen, mon_data, alu_zero);
      end
      wr_imem(0, rtype(5, 5, 0, 6'h20));
      wr_imem(1, rtype(0, 5, 20, 6'h20));
      wr_imem(2, HALT);
      run_dut(cyc, seen);
      n_cmp++;
      if (!seen || mon_data !== 32'd20) begin
         n_bad++;
         $display("FAIL reg0_write: got seen=%0d mon=%0d expected 1/20",
                  seen, mon_data);
      end
      m_reg[20] = 20; m_zero = 0;
   endtask

   task automatic test_illegal;
      int cyc; bit seen;
      wr_reg(20, 77);
      wr_imem(0, {6'h23, 26'h1234567}); wr_imem(1, HALT);
      run_dut(cyc, seen);
      n_cmp++;
      if (!seen || illegal !== 1'b1 || instr_count !== 16'd1) begin
         n_bad++;
         $display("FAIL illegal_op: got seen=%0d ill=%b cnt=%0d expected 1/1/1",
                  seen, illegal, instr_count);
      end
      n_cmp++;
      if (mon_data !== 32'd77) begin
         n_bad++;
         $display("FAIL illegal_nowrite: got %0d expected 77", mon_data);
      end
      wr_imem(0, rtype(9, 0, 20, 6'h3F));
      run_dut(cyc, seen);
      n_cmp++;
      if (illegal !== 1'b1 || mon_data !== 32'd77) begin
         n_bad++;
         $display("FAIL bad_funct: got ill=%b mon=%0d expected 1/77",
                  illegal, mon_data);
      end
      wr_imem(0, rtype(9, 0, 20, 6'h25));
      run_dut(cyc, seen);
      n_cmp++;
      if (illegal !== 1'b0 || mon_data !== 32'd100) begin
         n_bad++;
         $display("FAIL illegal_clear: got ill=%b mon=%0d expected 0/100",
                  illegal, mon_data);
      end
      m_reg[20] = 100; m_zero = 0;
   endtask

   task automatic test_start_with_write;
      int cyc; bit seen;
      wr_imem(0, rtype(9, 0, 20, 6'h25)); wr_imem(1, HALT);
      reg_we = 1'b1; reg_waddr = 5'd9; reg_wdata = 32'h1234; start = 1'b1;
      @(posedge clk); #1 reg_we = 1'b0; start = 1'b0;
      wait_done(cyc, seen);
      n_cmp++;
      if (!seen || mon_data !== 32'h1234) begin
         n_bad++;
         $display("FAIL start_with_write: got seen=%0d mon=%h expected 1/1234",
                  seen, mon_data);
      end
      m_reg[9] = 32'h1234; m_reg[20] = 32'h1234;
   endtask

   task automatic test_busy_ignore;
      int cyc; bit seen;
      wr_reg(9, 100);
      wr_imem(0, rtype(9, 0, 20, 6'h25)); wr_imem(1, HALT);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      imem_we = 1'b1; imem_waddr = 4'd1;
      imem_wdata = rtype(9, 9, 20, 6'h20); start = 1'b1;
      @(posedge clk); #1 imem_we = 1'b0; start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reg_we = 1'b1; reg_waddr = 5'd20; reg_wdata = 32'd555;
      @(posedge clk); #1 reg_we = 1'b0;
      wait_done(cyc, seen);
      n_cmp++;
      if (!seen || mon_data !== 32'd100 || instr_count !== 16'd1) begin
         n_bad++;
         $display("FAIL busy_ignore: got seen=%0d mon=%0d cnt=%0d expected 1/100/1",
                  seen, mon_data, instr_count);
      end
      m_reg[20] = 100; m_zero = 0;
   endtask

   task automatic test_no_wrap;
      int cyc; bit seen;
      wr_reg(1, 1); wr_reg(20, 0);
      for (int i = 0; i < 16; i++) wr_imem(i, rtype(20, 1, 20, 6'h20));
      run_dut(cyc, seen);
      n_cmp++;
      if (!seen || cyc != 64) begin
         n_bad++;
         $display("FAIL nowrap_cycles: got seen=%0d cyc=%0d expected 1/64",
                  seen, cyc);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || instr_count !== 16'd16 || mon_data !== 32'd16) begin
         n_bad++;
         $display("FAIL nowrap_hold: got busy=%b cnt=%0d mon=%0d expected 0/16/16",
                  busy, instr_count, mon_data);
      end
      m_reg[20] = 16; m_zero = 0;
   endtask

   task automatic test_reset_midrun;
      int cyc; bit seen;
      wr_reg(15, 999); wr_reg(9, 100);
      wr_imem(0, 32'h01E9A022); wr_imem(1, HALT);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || mon_data !== 32'd0) begin
         n_bad++;
         $display("FAIL async_reset: got busy=%b mon=%0d expected 0/0",
                  busy, mon_data);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      m_zero = 0;
      wr_reg(15, 999); wr_reg(9, 100);
      run_dut(cyc, seen);
      n_cmp++;
      if (!seen || cyc != 6 || mon_data !== 32'd899 ||
          instr_count !== 16'd1) begin
         n_bad++;
         $display("FAIL rerun: got seen=%0d cyc=%0d mon=%0d cnt=%0d expected 1/6/899/1",
                  seen, cyc, mon_data, instr_count);
      end
      m_reg[20] = 899;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] f;
      int r;
      logic [5:0] fl [6];
      fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      r = $urandom_range(0, 9);
      if (r == 0)
         return {6'($urandom_range(1, 62)), 26'($urandom)};
      if (r == 1) begin
         f = 6'($urandom);
         while (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A})
            f = 6'($urandom);
      end else begin
         f = fl[$urandom_range(0, 5)];
      end
      return rtype($urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), f);
   endfunction

   task automatic test_random;
      int cyc, mcyc, mcnt, len;
      bit seen, mill;
      for (int it = 0; it < 10; it++) begin
         for (int r = 1; r < 32; r++)
            wr_reg(r, ($urandom_range(0, 2) == 0) ?
                      32'($urandom_range(0, 3)) : $urandom);
         len = (it % 4 == 3) ? 15 : $urandom_range(1, 13);
         for (int i = 0; i < 16; i++) begin
            if (i < len) wr_imem(i, rand_instr());
            else if (i == len)
               wr_imem(i, rtype($urandom_range(0, 31), 0, 20, 6'h25));
            else if (i == len + 1) wr_imem(i, HALT);
            else wr_imem(i, rand_instr());
         end
         model_run(mcnt, mill, mcyc);
         run_dut(cyc, seen);
         n_cmp++;
         if (!seen || cyc != mcyc) begin
            n_bad++;
            $display("FAIL rand%0d_cycles: got seen=%0d cyc=%0d expected 1/%0d",
                     it, seen, cyc, mcyc);
         end
         n_cmp++;
         if (mon_data !== m_reg[20] || alu_zero !== m_zero) begin
            n_bad++;
            $display("FAIL rand%0d_data: got mon=%h z=%b expected %h/%b",
                     it, mon_data, alu_zero, m_reg[20], m_zero);
         end
         n_cmp++;
         if (instr_count !== 16'(mcnt) || illegal !== mill) begin
            n_bad++;
            $display("FAIL rand%0d_status: got cnt=%0d ill=%b expected %0d/%b",
                     it, instr_count, illegal, mcnt, mill);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      for (int i = 0; i < 16; i++) m_imem[i] = 0;
      m_zero = 0;
      @(posedge clk); #1;
      test_reset();
      test_sub_899();
      test_add_1019();
      test_zero();
      test_illegal();
      test_start_with_write();
      test_busy_ignore();
      test_no_wrap();
      test_reset_midrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
